io_cond_ring: RTL and testbench
===============================

# io_cond_ring

Parametrised pad-side conditioning ring for the ZigBee top level. It sits between the pad cells (ITP input pads, BU12SP output pads) and the `TOP` core. Each input channel gets a multi-stage synchroniser, a glitch filter and rise/fall pulses, and each output channel is registered. A loopback mode drives the output pads from the filtered inputs for board and tester checks without the core.

## Interface
Parameters:
- `N_IN`, 24, number of input channels; must be ≥ `N_OUT`.
- `N_OUT`, 16, number of output channels.
- `SYNC_STAGES`, 2, synchroniser depth; must be ≥ 2.
- `FILT_LEN`, 3, consecutive cycles a new value must persist before it is accepted; must be ≥ 1.

Ports:
- `inClock`  in  1  single clock for the whole block.
- `inReset`  in  1  asynchronous, active-low reset.
- `inPadIn`  in  N_IN  raw levels from the ITP `Y` outputs.
- `inFilterBypass`  in  1  1 = skip the glitch filter.
- `inLoopback`  in  1  1 = output pads mirror the filtered inputs.
- `inCoreOut`  in  N_OUT  core outputs.
- `outCoreIn`  out  N_IN  filtered input levels to the core.
- `outCoreRise`  out  N_IN  one-cycle pulse when a filtered level rises.
- `outCoreFall`  out  N_IN  one-cycle pulse when a filtered level falls.
- `outChanged`  out  1  OR-reduction of all rise and fall pulses, registered.
- `outPadOut`  out  N_OUT  to the BU12SP `A` pins.

## Operation
- Reset (`inReset`=0, async): all synchroniser flops, filter counters, `outCoreIn`, `outCoreRise`, `outCoreFall`, `outChanged` and `outPadOut` go to 0.
- Per input channel `i`:
  - The synchroniser samples `inPadIn[i]` into `SYNC_STAGES` flops; `s` is the last stage.
  - Filter counter `cnt` has width clog2(`FILT_LEN`).
  - If `s` == level: `cnt` ← 0.
  - Else if `cnt` == `FILT_LEN`-1: level ← `s`, `cnt` ← 0.
  - Else: `cnt` ← `cnt`+1.
- Edge pulses: `outCoreRise[i]` and `outCoreFall[i]` are registered. Each is high for exactly one cycle, the same cycle in which `outCoreIn[i]` first shows its new value. Rise and fall are never high together on one channel.
- Filter bypass (`inFilterBypass`=1):
  - All counters are held at 0 and level ← `s` every cycle.
  - Edge pulses are still generated.
  - Toggling bypass mid-count clears counters. A pending change is then either taken immediately (bypass=1) or restarts its count (bypass=0).
- Output path:
  - `inLoopback`=0: `outPadOut` ← `inCoreOut`.
  - `inLoopback`=1: `outPadOut[j]` ← `outCoreIn[j]` for j < `N_OUT`.
  - A mode change takes effect at the next edge. `outPadOut` comes directly from flops, so it is glitch-free.
- `outChanged` ← OR of all `outCoreRise` and `outCoreFall` bits in the current cycle, so it lags the pulses by 1 cycle.
- Simultaneous changes on several channels are independent; there is no arbitration.

## Timing
- Input latency with the filter active: `outCoreIn[i]` changes on the (`SYNC_STAGES`+`FILT_LEN`)-th rising edge after the pad change. The first sampling edge counts as 1. Defaults give 5.
- Input latency in bypass: edge `SYNC_STAGES`+1. Defaults give 3.
- Glitch rejection: a pad pulse seen at `s` for fewer than `FILT_LEN` consecutive cycles never reaches `outCoreIn`. A pulse of exactly `FILT_LEN` cycles passes.
- `FILT_LEN`=1: the filter acts as one extra register stage.
- Output latency: 1 cycle from `inCoreOut` or `outCoreIn` to `outPadOut`.
- Reset deassertion is taken asynchronously. The level-sensitive reset release is synchronised externally at the pad ring. The first functional sample is taken on the first edge after release.
- Reset asserted mid-count: counters and levels clear immediately, and no edge pulse is emitted on reset.

## Structure
- Package `io_cond_pkg` holds:
  - the default constants `IO_N_IN`, `IO_N_OUT`, `IO_SYNC_STAGES`, `IO_FILT_LEN`;
  - the counter-width function `io_cnt_w(len)`;
  - the parameter legality checks (elaborate-time assertions).
- Sub-module `io_cond_chan` implements one input channel: synchroniser, filter and edge pulses. It is generate-instantiated `N_IN` times.
- The top of `io_cond_ring` contains the output register, the loopback mux and `outChanged`.

## Test plan
- Reset, then drive `inPadIn`=0 steady → all outputs stay 0; drive bit 5 to 1 → `outCoreIn[5]` rises on edge 5, `outCoreRise[5]` is high for that one cycle, `outChanged` is high one cycle later.
- Drive a 2-cycle high glitch on bit 0 (defaults) → `outCoreIn[0]` and all pulses stay 0. Drive a 3-cycle pulse → `outCoreIn[0]` goes high for 3 cycles, with one rise pulse and one fall pulse.
- Set `inFilterBypass`=1 and toggle bit 7 → `outCoreIn[7]` follows on edge 3 and the same 2-cycle glitch passes. Release bypass mid-count → the count restarts.
- Set `inLoopback`=0 and `inCoreOut`=16'hA5C3 → `outPadOut`=16'hA5C3 one cycle later. Set `inLoopback`=1 with filtered `outCoreIn`[15:0]=16'h1234 → `outPadOut`=16'h1234 one cycle later.
- Assert `inReset` while bit 3 is mid-count, with `cnt`=1 → all outputs are 0 immediately with no pulse. After release, the still-high pad bit 3 is accepted 5 edges later.
- Change bits 0, 8 and 23 on the same edge, with 0→1 on bits 0 and 8 and 1→0 on bit 23 → all three levels update on the same edge, with rise pulses on bits 0 and 8, a fall pulse on bit 23, and a single `outChanged` cycle.

Source files
------------

// File: rtl/io_cond_pkg.sv
// Shared constants and helpers for the pad-side conditioning ring.
// The legality check runs once per top-level instance while the design is elaborated.
package io_cond_pkg;

    localparam int IO_N_IN        = 24;
    localparam int IO_N_OUT       = 16;
    localparam int IO_SYNC_STAGES = 2;
    localparam int IO_FILT_LEN    = 3;

    // A filter length of 1 still needs a 1-bit counter so that the port widths stay legal.
    function automatic int io_cnt_w(input int len);
        return (len <= 1) ? 1 : $clog2(len);
    endfunction

    function automatic bit io_params_ok(input int n_in, input int n_out,
                                        input int sync_stages, input int filt_len);
        return (n_out >= 1) && (n_in >= n_out) && (sync_stages >= 2) && (filt_len >= 1);
    endfunction

endpackage

// File: rtl/io_cond_chan.sv
// One input channel: multi-flop synchroniser, persistence filter and registered edge pulses.
module io_cond_chan
    import io_cond_pkg::*;
#(
    parameter int SYNC_STAGES = IO_SYNC_STAGES,
    parameter int FILT_LEN    = IO_FILT_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    input  logic bypass,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = io_cnt_w(FILT_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_p;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_next;
    logic                   level_next;
    logic                   s;

    assign s = sync_p[SYNC_STAGES-1];

    always_comb begin
        cnt_next   = '0;
        level_next = level;
        if (bypass) begin
            level_next = s;
        end else if (s == level) begin
            cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
            level_next = s;
        end else begin
            cnt_next = cnt + CW'(1);
        end
    end

    // Pulses are registered with the level so they line up with the new value on outCoreIn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], pad};
            cnt    <= cnt_next;
            level  <= level_next;
            rise   <= level_next & ~level;
            fall   <= ~level_next & level;
        end
    end

endmodule

// File: rtl/io_cond_ring.sv
// Pad conditioning ring: per-channel input conditioning plus the registered output pads
// with a loopback path that lets the board or tester exercise the pads without the core.
module io_cond_ring
    import io_cond_pkg::*;
#(
    parameter int N_IN        = IO_N_IN,
    parameter int N_OUT       = IO_N_OUT,
    parameter int SYNC_STAGES = IO_SYNC_STAGES,
    parameter int FILT_LEN    = IO_FILT_LEN
) (
    input  logic             inClock,
    input  logic             inReset,
    input  logic [N_IN-1:0]  inPadIn,
    input  logic             inFilterBypass,
    input  logic             inLoopback,
    input  logic [N_OUT-1:0] inCoreOut,
    output logic [N_IN-1:0]  outCoreIn,
    output logic [N_IN-1:0]  outCoreRise,
    output logic [N_IN-1:0]  outCoreFall,
    output logic             outChanged,
    output logic [N_OUT-1:0] outPadOut
);

    if (!io_params_ok(N_IN, N_OUT, SYNC_STAGES, FILT_LEN)) begin : g_bad_params
        $error("io_cond_ring: illegal parameter combination");
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_chan
        io_cond_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN   (FILT_LEN)
        ) u_chan (
            .clk   (inClock),
            .rst_n (inReset),
            .pad   (inPadIn[i]),
            .bypass(inFilterBypass),
            .level (outCoreIn[i]),
            .rise  (outCoreRise[i]),
            .fall  (outCoreFall[i])
        );
    end

    // Pads are driven straight from flops so a loopback switch cannot glitch them.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            outPadOut  <= '0;
            outChanged <= 1'b0;
        end else begin
            outPadOut  <= inLoopback ? outCoreIn[N_OUT-1:0] : inCoreOut;
            outChanged <= |{outCoreRise, outCoreFall};
        end
    end

endmodule

// File: tb/tb_io_cond_ring.sv
// Scoreboard bench for io_cond_ring with default parameters: stimulus queues expected output
// snapshots with their arrival cycle; a monitor pops one whenever the outputs change.
module tb_io_cond_ring;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pad;
    logic        bypass;
    logic        lb;
    logic [15:0] core;
    logic [23:0] cin;
    logic [23:0] rise;
    logic [23:0] fall;
    logic        chg;
    logic [15:0] pout;

    io_cond_ring dut (
        .inClock       (clk),
        .inReset       (rst_n),
        .inPadIn       (pad),
        .inFilterBypass(bypass),
        .inLoopback    (lb),
        .inCoreOut     (core),
        .outCoreIn     (cin),
        .outCoreRise   (rise),
        .outCoreFall   (fall),
        .outChanged    (chg),
        .outPadOut     (pout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [23:0] cin;
        logic [23:0] rise;
        logic [23:0] fall;
        logic        chg;
        logic [15:0] pout;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [23:0] m_pad;
    logic [23:0] m_cin;
    logic [15:0] m_pout;

    always @(posedge clk) cyc++;

    task automatic push(input int c, input logic [23:0] ci, input logic [23:0] r,
                        input logic [23:0] f, input logic ch, input logic [15:0] po,
                        input string nm);
        exp_t e;
        e.cyc = c; e.cin = ci; e.rise = r; e.fall = f; e.chg = ch; e.pout = po; e.name = nm;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Full-acceptance pad change with loopback off: level plus pulse at +lat, outChanged next.
    task automatic pad_change(input logic [23:0] nv, input int lat, input string nm);
        int          d;
        logic [23:0] ch;
        d     = cyc;
        ch    = m_pad ^ nv;
        m_pad = nv;
        pad   = nv;
        m_cin = nv;
        push(d + lat,     nv, ch & nv, ch & ~nv, 1'b0, m_pout, {nm, "_lvl"});
        push(d + lat + 1, nv, '0, '0, 1'b1, m_pout, {nm, "_chg"});
        push(d + lat + 2, nv, '0, '0, 1'b0, m_pout, {nm, "_idle"});
        step(lat + 3);
    endtask

    // Monitor: every observable output change must match the head of the scoreboard.
    logic [88:0] prev;
    logic [88:0] cur;
    always @(negedge clk) begin
        exp_t e;
        cur = {cin, rise, fall, chg, pout};
        if (mon_en) begin
            if (cur != prev) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d got cin=%h rise=%h fall=%h chg=%b pout=%h required no change",
                             cyc, cin, rise, fall, chg, pout);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.cin != cin || e.rise != rise || e.fall != fall ||
                        e.chg != chg || e.pout != pout) begin
                        bad++;
                        $display("FAIL %s got cyc=%0d cin=%h rise=%h fall=%h chg=%b pout=%h required cyc=%0d cin=%h rise=%h fall=%h chg=%b pout=%h",
                                 e.name, cyc, cin, rise, fall, chg, pout,
                                 e.cyc, e.cin, e.rise, e.fall, e.chg, e.pout);
                    end
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL %s got no change by cyc=%0d required change at cyc=%0d",
                         e.name, cyc, e.cyc);
            end
        end
        prev = cur;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        rst_n = 1'b0; pad = '0; bypass = 1'b0; lb = 1'b0; core = '0;
        m_pad = '0; m_cin = '0; m_pout = '0;
        step(3);
        total++;
        if ({cin, rise, fall, chg, pout} != '0) begin
            bad++;
            $display("FAIL reset_state got cin=%h rise=%h fall=%h chg=%b pout=%h required all 0",
                     cin, rise, fall, chg, pout);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        step(10);

        // Single rising channel with the filter active.
        pad_change(24'h000020, 5, "bit5_rise");
        pad_change(24'h000000, 5, "bit5_fall");

        // Two-cycle glitch is rejected.
        pad[0] = 1'b1; step(2); pad[0] = 1'b0; step(10);

        // Three-cycle pulse passes for exactly three cycles.
        d = cyc;
        push(d + 5,  24'h000001, 24'h000001, '0, 1'b0, m_pout, "p3_rise");
        push(d + 6,  24'h000001, '0, '0, 1'b1, m_pout, "p3_rise_chg");
        push(d + 7,  24'h000001, '0, '0, 1'b0, m_pout, "p3_rise_idle");
        push(d + 8,  24'h000000, '0, 24'h000001, 1'b0, m_pout, "p3_fall");
        push(d + 9,  24'h000000, '0, '0, 1'b1, m_pout, "p3_fall_chg");
        push(d + 10, 24'h000000, '0, '0, 1'b0, m_pout, "p3_fall_idle");
        pad[0] = 1'b1; step(3); pad[0] = 1'b0; step(10);

        // Bypass: three-edge latency and the two-cycle glitch gets through.
        bypass = 1'b1; step(1);
        pad_change(24'h000080, 3, "byp_rise");
        d = cyc;
        push(d + 3, 24'h000000, '0, 24'h000080, 1'b0, m_pout, "byp_gl_fall");
        push(d + 4, 24'h000000, '0, '0, 1'b1, m_pout, "byp_gl_fall_chg");
        push(d + 5, 24'h000080, 24'h000080, '0, 1'b0, m_pout, "byp_gl_rise");
        push(d + 6, 24'h000080, '0, '0, 1'b1, m_pout, "byp_gl_rise_chg");
        push(d + 7, 24'h000080, '0, '0, 1'b0, m_pout, "byp_gl_idle");
        pad[7] = 1'b0; step(2); pad[7] = 1'b1; step(8);

        // Bypass released before the change reaches s: full filter latency applies.
        d = cyc;
        push(d + 5, 24'h000000, '0, 24'h000080, 1'b0, m_pout, "rel_fall");
        push(d + 6, 24'h000000, '0, '0, 1'b1, m_pout, "rel_fall_chg");
        push(d + 7, 24'h000000, '0, '0, 1'b0, m_pout, "rel_fall_idle");
        pad[7] = 1'b0; step(1); bypass = 1'b0; step(10);

        // Bypass pulsed while cnt=1: the pending change is taken on that edge.
        d = cyc;
        push(d + 4, 24'h000080, 24'h000080, '0, 1'b0, m_pout, "take_rise");
        push(d + 5, 24'h000080, '0, '0, 1'b1, m_pout, "take_rise_chg");
        push(d + 6, 24'h000080, '0, '0, 1'b0, m_pout, "take_rise_idle");
        pad[7] = 1'b1; step(3); bypass = 1'b1; step(1); bypass = 1'b0; step(8);
        m_pad = 24'h000080; m_cin = 24'h000080;
        pad_change(24'h000000, 5, "bit7_clear");

        // Output path: core drive, then loopback of the filtered inputs, then back.
        d = cyc; core = 16'hA5C3; m_pout = 16'hA5C3;
        push(d + 1, m_cin, '0, '0, 1'b0, 16'hA5C3, "core_out");
        step(3);
        pad_change(24'h001234, 5, "lb_pads");
        d = cyc; lb = 1'b1;
        push(d + 1, m_cin, '0, '0, 1'b0, 16'h1234, "loopback_on");
        step(3);
        d = cyc; lb = 1'b0;
        push(d + 1, m_cin, '0, '0, 1'b0, 16'hA5C3, "loopback_off");
        step(3);

        // Reset while bit 3 sits at cnt=1.
        d = cyc; m_pad = 24'h00123C; pad = m_pad;
        step(3);
        rst_n = 1'b0;
        push(d + 3,  '0, '0, '0, 1'b0, 16'h0000, "rst_clear");
        push(d + 5,  '0, '0, '0, 1'b0, 16'hA5C3, "rst_pout");
        push(d + 9,  24'h00123C, 24'h00123C, '0, 1'b0, 16'hA5C3, "rst_accept");
        push(d + 10, 24'h00123C, '0, '0, 1'b1, 16'hA5C3, "rst_accept_chg");
        push(d + 11, 24'h00123C, '0, '0, 1'b0, 16'hA5C3, "rst_accept_idle");
        step(1); rst_n = 1'b1;
        step(12);
        m_cin = 24'h00123C;

        // Simultaneous changes on several channels.
        pad_change(24'h800000, 5, "set23");
        pad_change(24'h000101, 5, "multi");
        step(5);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
